line_window_gen: RTL and testbench

- Read side and write-back controller for the filter's two 8-bit line RAMs (write port A, registered read port B, 1-cycle read latency, 11-bit addresses).
- Accepts a raster pixel stream.
- Issues line-RAM reads, absorbs their latency, and rotates rows through the RAMs.
- Presents a 3x3 pixel window per valid position to the 2D FIR datapath.

---
 rtl/filt_pkg.sv | 12 +
 rtl/line_window_gen_if.sv | 23 ++
 rtl/win3x3_shift.sv | 50 +++++
 rtl/line_window_gen.sv | 79 +++++++
 tb/tb_line_window_gen.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/filt_pkg.sv
// Shared constants and helpers for the 2D FIR front end: pixel and line-RAM
// widths, window size, and the byte position of tap (r,c) inside a packed window.
package filt_pkg;
  localparam int DW       = 8;
  localparam int AW       = 11;
  localparam int WIN_TAPS = 9;

  // Byte index of the window tap at row r (0 = top) and column c (0 = leftmost)
  function automatic int idx(input int r, input int c);
    return 3 * r + c;
  endfunction
endpackage

// File: rtl/line_window_gen_if.sv
// Port bundle between the window generator and its two dual-port line RAMs
// (write port A shared, registered read port B shared, one cycle read latency).
interface line_window_gen_if;
  import filt_pkg::*;

  logic [AW-1:0] lb_raddr;
  logic [DW-1:0] lb0_rdata;
  logic [DW-1:0] lb1_rdata;
  logic          lb_we;
  logic [AW-1:0] lb_waddr;
  logic [DW-1:0] lb0_wdata;
  logic [DW-1:0] lb1_wdata;

  modport master (
    output lb_raddr, lb_we, lb_waddr, lb0_wdata, lb1_wdata,
    input  lb0_rdata, lb1_rdata
  );

  modport slave (
    input  lb_raddr, lb_we, lb_waddr, lb0_wdata, lb1_wdata,
    output lb0_rdata, lb1_rdata
  );
endinterface

// File: rtl/win3x3_shift.sv
// 3x3 pixel shift register: shifts a new column in from the right on shift_en and
// captures the post-shift window into the packed output on load_en.
module win3x3_shift
  import filt_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     load_en,
  input  logic [DW-1:0]            top_px,
  input  logic [DW-1:0]            mid_px,
  input  logic [DW-1:0]            bot_px,
  output logic [WIN_TAPS*DW-1:0]   win_data
);

  logic [DW-1:0] w   [3][3];
  logic [DW-1:0] nw  [3][3];
  logic [DW-1:0] new_col [3];

  always_comb begin
    new_col[0] = top_px;
    new_col[1] = mid_px;
    new_col[2] = bot_px;
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = w[r][1];
      nw[r][1] = w[r][2];
      nw[r][2] = new_col[r];
    end
  end

  // The output register is loaded from the post-shift view so the window and
  // its strobe leave in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
      win_data <= '0;
    end else begin
      if (shift_en)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            w[r][c] <= nw[r][c];
      if (load_en)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            win_data[idx(r, c)*DW +: DW] <= nw[r][c];
    end
  end
endmodule

// File: rtl/line_window_gen.sv
// Raster pixel stream in, 3x3 windows out; drives the two line RAMs so that
// RAM 0 holds row y-1 and RAM 1 holds row y-2 at every column.
module line_window_gen
  import filt_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  // s_valid qualifies s_data for exactly one cycle; there is no ready, every
  // strobed pixel is consumed. win_valid likewise marks one window per cycle.
  input  logic                    s_valid,
  input  logic [DW-1:0]           s_data,
  line_window_gen_if.master       lb,
  output logic                    win_valid,
  output logic [WIN_TAPS*DW-1:0]  win_data,
  output logic                    frame_done
);

  localparam int RW = 12;

  logic [AW-1:0] col, col1;
  logic [RW-1:0] row, row1;
  logic          v1;
  logic [DW-1:0] s_data1;
  logic          win_hit;
  logic          last_px;

  assign win_hit = v1 && (row1 >= RW'(2)) && (col1 >= AW'(2));
  assign last_px = v1 && (col1 == AW'(WIDTH - 1)) && (row1 == RW'(HEIGHT - 1));

  // Read for the incoming pixel while stage 1 writes the previous column back,
  // so the two ports never touch the same address in one cycle.
  assign lb.lb_raddr  = col;
  assign lb.lb_we     = v1;
  assign lb.lb_waddr  = col1;
  assign lb.lb0_wdata = s_data1;
  assign lb.lb1_wdata = v1 ? lb.lb0_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      col1       <= '0;
      row1       <= '0;
      v1         <= 1'b0;
      s_data1    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      v1         <= s_valid;
      win_valid  <= win_hit;
      frame_done <= last_px;
      if (s_valid) begin
        s_data1 <= s_data;
        col1    <= col;
        row1    <= row;
        if (col == AW'(WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(HEIGHT - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + AW'(1);
        end
      end
    end
  end

  win3x3_shift u_win (
    .clk      (clk),
    .rst      (rst),
    .shift_en (v1),
    .load_en  (win_hit),
    .top_px   (lb.lb1_rdata),
    .mid_px   (lb.lb0_rdata),
    .bot_px   (s_data1),
    .win_data (win_data)
  );
endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen: 4x4 frames through behavioural line RAMs with a
// window scoreboard, plus a 2000-wide instance exercising line-RAM addressing.
module tb_line_window_gen;
  import filt_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int BW = 2000;
  localparam int BH = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // small DUT
  logic                   s_valid = 1'b0;
  logic [DW-1:0]          s_data  = '0;
  logic                   win_valid, frame_done;
  logic [WIN_TAPS*DW-1:0] win_data;
  line_window_gen_if lb_a ();

  line_window_gen #(.WIDTH(W), .HEIGHT(H)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .lb         (lb_a.master),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .frame_done (frame_done)
  );

  logic [DW-1:0] ram0_a [2048];
  logic [DW-1:0] ram1_a [2048];
  logic [DW-1:0] q0_a = '0, q1_a = '0;
  always @(posedge clk) begin
    if (lb_a.lb_we) begin
      ram0_a[lb_a.lb_waddr] <= lb_a.lb0_wdata;
      ram1_a[lb_a.lb_waddr] <= lb_a.lb1_wdata;
    end
    q0_a <= ram0_a[lb_a.lb_raddr];
    q1_a <= ram1_a[lb_a.lb_raddr];
  end
  assign lb_a.lb0_rdata = q0_a;
  assign lb_a.lb1_rdata = q1_a;

  // wide DUT
  logic                   sv_b = 1'b0;
  logic [DW-1:0]          sd_b = '0;
  logic                   wv_b, fd_b;
  logic [WIN_TAPS*DW-1:0] wd_b;
  line_window_gen_if lb_b ();

  line_window_gen #(.WIDTH(BW), .HEIGHT(BH)) u_big (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (sv_b),
    .s_data     (sd_b),
    .lb         (lb_b.master),
    .win_valid  (wv_b),
    .win_data   (wd_b),
    .frame_done (fd_b)
  );

  logic [DW-1:0] ram0_b [2048];
  logic [DW-1:0] ram1_b [2048];
  logic [DW-1:0] q0_b = '0, q1_b = '0;
  always @(posedge clk) begin
    if (lb_b.lb_we) begin
      ram0_b[lb_b.lb_waddr] <= lb_b.lb0_wdata;
      ram1_b[lb_b.lb_waddr] <= lb_b.lb1_wdata;
    end
    q0_b <= ram0_b[lb_b.lb_raddr];
    q1_b <= ram1_b[lb_b.lb_raddr];
  end
  assign lb_b.lb0_rdata = q0_b;
  assign lb_b.lb1_rdata = q1_b;

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [WIN_TAPS*DW:0]   exp_q[$];
  logic [WIN_TAPS*DW-1:0] got_q[$];
  int   win_cnt  = 0;
  int   done_cnt = 0;
  int   win_b    = 0;
  int   done_b   = 0;
  logic sv_q     = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // bench's own record of which cycles carry an accepted pixel in stage 1
  always @(posedge clk) sv_q <= rst ? 1'b0 : s_valid;

  // monitor for the small DUT
  always @(negedge clk) begin
    logic [WIN_TAPS*DW:0] e;
    check("lb_we", {79'b0, lb_a.lb_we}, {79'b0, sv_q});
    if (win_valid) begin
      check("win_expected", {79'b0, win_valid}, {79'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("window", {7'b0, frame_done, win_data}, {7'b0, e});
      end
      got_q.push_back(win_data);
      win_cnt++;
      if (frame_done) done_cnt++;
    end else begin
      check("stray_frame_done", {79'b0, frame_done}, 80'b0);
    end
  end

  // monitor for the wide DUT
  always @(negedge clk) begin
    if (wv_b) win_b++;
    if (fd_b) done_b++;
  end

  // expected window for a 4x4 frame whose pixel (x,y) equals base + y*W + x
  function automatic logic [WIN_TAPS*DW:0] exp_win(input int base, input int x, input int y);
    logic [WIN_TAPS*DW:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[idx(r, c)*DW +: DW] = DW'(base + (y - 2 + r) * W + (x - 2 + c));
    v[WIN_TAPS*DW] = (x == W - 1) && (y == H - 1);
    return v;
  endfunction

  // driver tasks
  task automatic send_frame(input int base, input int gap_max, input int npix);
    for (int i = 0; i < npix; i++) begin
      int x, y, g;
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        s_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      x = i % W;
      y = i / W;
      s_valid = 1'b1;
      s_data  = DW'(base + i);
      if (x >= 2 && y >= 2) exp_q.push_back(exp_win(base, x, y));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic drain_and_count(input string tag, input int n_win, input int n_done);
    repeat (6) begin @(posedge clk); #1; end
    check({tag, "_win_count"}, 80'(win_cnt), 80'(n_win));
    check({tag, "_done_count"}, 80'(done_cnt), 80'(n_done));
    check({tag, "_queue_empty"}, 80'(exp_q.size()), 80'd0);
  endtask

  task automatic clear_counts();
    win_cnt  = 0;
    done_cnt = 0;
    got_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram0_a[i] = DW'($urandom_range(0, 255));
      ram1_a[i] = DW'($urandom_range(0, 255));
      ram0_b[i] = DW'($urandom_range(0, 255));
      ram1_b[i] = DW'($urandom_range(0, 255));
    end

    // reset held with pixels strobing
    rst = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = DW'($urandom_range(0, 255));
      @(posedge clk); #1;
      check("rst_win_valid", {79'b0, win_valid}, 80'b0);
      check("rst_frame_done", {79'b0, frame_done}, 80'b0);
      check("rst_lb_we", {79'b0, lb_a.lb_we}, 80'b0);
      check("rst_win_data", 80'(win_data), 80'b0);
      check("rst_lb_raddr", 80'(lb_a.lb_raddr), 80'b0);
    end
    s_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // basic ramp frame
    clear_counts();
    send_frame(0, 0, 16);
    drain_and_count("basic", 4, 1);
    if (got_q.size() == 4) begin
      check("basic_first", 80'(got_q[0]), 80'h0a0908060504020100);
      check("basic_last",  80'(got_q[3]), 80'h0f0e0d0b0a09070605);
    end else begin
      check("basic_got_size", 80'(got_q.size()), 80'd4);
    end

    // same frame with random gaps
    clear_counts();
    send_frame(0, 5, 16);
    drain_and_count("gaps", 4, 1);
    if (got_q.size() == 4) begin
      check("gaps_first", 80'(got_q[0]), 80'h0a0908060504020100);
      check("gaps_last",  80'(got_q[3]), 80'h0f0e0d0b0a09070605);
    end

    // back-to-back frames, second offset by 100
    clear_counts();
    send_frame(0, 0, 16);
    send_frame(100, 0, 16);
    drain_and_count("b2b", 8, 2);
    if (got_q.size() == 8)
      check("b2b_frame2_first", 80'(got_q[4]), 80'h6e6d6c6a6968666564);

    // reset after pixel 9 of a frame, then a full new frame
    clear_counts();
    send_frame(0, 0, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("abort_no_windows", 80'(win_cnt), 80'd0);
    send_frame(50, 0, 16);
    drain_and_count("after_rst", 4, 1);
    if (got_q.size() == 4)
      check("after_rst_first", 80'(got_q[0]), 80'h3c3b3a383736343332);

    // wide line: address sweep and wrap
    for (int i = 0; i < BW * BH; i++) begin
      sv_b = 1'b1;
      sd_b = DW'(i);
      check("big_raddr", 80'(lb_b.lb_raddr), 80'(i % BW));
      @(posedge clk); #1;
      check("big_we", {79'b0, lb_b.lb_we}, 80'd1);
      check("big_waddr", 80'(lb_b.lb_waddr), 80'(i % BW));
      check("big_addr_distinct", {79'b0, lb_b.lb_raddr == lb_b.lb_waddr}, 80'd0);
    end
    sv_b = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("big_win_count", 80'(win_b), 80'((BW - 2) * (BH - 2)));
    check("big_done_count", 80'(done_b), 80'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
